// File: rtl/adc_sample_packer.sv
// adc_sample_packer
// Takes one 64-bit ADC word per valid cycle and keeps one word out of every
// dec_ratio+1. Kept words are paired into 128-bit beats {second, first}.
// Beats are buffered in a small FIFO in front of an AXI-Stream master.
// The ADC side cannot stall. A beat that finds the FIFO full, with no pop in
// the same cycle, is dropped and counted. tlast framing counts only beats that
// actually entered the FIFO.

module adc_sample_packer #(
    parameter int FIFO_DEPTH  = 16,   // power of 2, >= 2
    parameter int BURST_BEATS = 256   // beats per tlast frame, >= 1
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic                          en,
    input  logic [7:0]                    dec_ratio,
    input  logic [63:0]                   s_data,
    input  logic                          s_valid,
    output logic [127:0]                  m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_BEATS - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input side: decimation and pairing
    // ------------------------------------------------------------------
    logic [7:0]    dec_cnt;
    logic          half;
    logic [63:0]   lo_reg;
    logic          accept;
    logic          keep;
    logic          push;

    assign accept = s_valid & en;
    assign keep   = accept & (dec_cnt == 8'd0);
    // A beat is complete when the second word of a pair is kept.
    assign push   = keep & half;

    // Decimation counter: reload on a kept word, count down otherwise.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            dec_cnt <= 8'd0;
        end else if (!en) begin
            dec_cnt <= 8'd0;
        end else if (s_valid) begin
            if (dec_cnt == 8'd0) dec_cnt <= dec_ratio;
            else                 dec_cnt <= dec_cnt - 8'd1;
        end
    end

    // Pair builder: hold the first kept word until its partner arrives.
    // Dropping en discards a half-built pair.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            half   <= 1'b0;
            lo_reg <= 64'd0;
        end else if (!en) begin
            half   <= 1'b0;
        end else if (keep) begin
            if (!half) begin
                lo_reg <= s_data;
                half   <= 1'b1;
            end else begin
                half   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [BW-1:0] beat_cnt;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [128:0]  wr_entry;
    logic [128:0]  head;

    assign full    = (count == FULL_LEVEL);
    assign pop     = m_axis_tvalid & m_axis_tready;
    // When the FIFO is full, a pop in the same cycle frees the slot being written.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign wr_entry = {(beat_cnt == LAST_BEAT), s_data, lo_reg};

    // Frame position of the next stored beat. Dropped beats do not advance it.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            beat_cnt <= '0;
        end else if (push_ok) begin
            if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
            else                       beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Beat storage, including the tlast flag of each beat.
    logic [128:0] mem [FIFO_DEPTH];

    // Write port of the storage array.
    // NOTE: the array has no reset. Validity comes only from the reset pointers
    // and count, so resetting the contents would add logic for no benefit.
    always_ff @(posedge axi_aclk) begin
        if (push_ok) mem[wr_ptr] <= wr_entry;
    end

    // Pointers and occupancy. Push and pop in the same cycle leave count unchanged.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Overflow bookkeeping. A drop in the same cycle as a clear takes priority.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr)                     drop_count <= 16'd1;
            else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end
    end

    // ------------------------------------------------------------------
    // AXI-Stream output: the head entry is presented directly.
    // It stays stable until popped because rd_ptr only moves on a pop.
    // ------------------------------------------------------------------
    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = (count != '0);
    // Output is gated so tdata and tlast read 0 whenever the FIFO is empty.
    assign m_axis_tdata  = m_axis_tvalid ? head[127:0] : 128'd0;
    assign m_axis_tlast  = m_axis_tvalid & head[128];
    assign fifo_level    = count;

endmodule
